// File: rtl/cbus_arbiter.sv
// cbus_arbiter: N-way arbiter that locks one upstream requester onto the single
// cbus master port for a whole transaction (including bursts) and routes the
// downstream response back to that requester only.
// Build option: define CBUS_ARBITER_ROUND_ROBIN_EN for round-robin selection;
// when undefined, selection is fixed priority with index 0 highest.
//
// state | meaning
// IDLE  | no grant held; outputs quiet; a winner is picked from ireq_valid
// BUSY  | grant locked to sel; forward request, route response until last beat
module cbus_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            ireq_valid,
  input  logic [NUM_INPUTS-1:0]            ireq_is_write,
  input  logic [3*NUM_INPUTS-1:0]          ireq_size,
  input  logic [ADDR_W*NUM_INPUTS-1:0]     ireq_addr,
  input  logic [(DATA_W/8)*NUM_INPUTS-1:0] ireq_strobe,
  input  logic [DATA_W*NUM_INPUTS-1:0]     ireq_data,
  input  logic [4*NUM_INPUTS-1:0]          ireq_len,
  input  logic [2*NUM_INPUTS-1:0]          ireq_burst,
  output logic [NUM_INPUTS-1:0]            iresp_ready,
  output logic [NUM_INPUTS-1:0]            iresp_last,
  output logic [DATA_W*NUM_INPUTS-1:0]     iresp_data,
  output logic                             oreq_valid,
  output logic                             oreq_is_write,
  output logic [2:0]                       oreq_size,
  output logic [ADDR_W-1:0]                oreq_addr,
  output logic [DATA_W/8-1:0]              oreq_strobe,
  output logic [DATA_W-1:0]                oreq_data,
  output logic [3:0]                       oreq_len,
  output logic [1:0]                       oreq_burst,
  input  logic                             oresp_ready,
  input  logic                             oresp_last,
  input  logic [DATA_W-1:0]                oresp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;

  // Per-port views of the flattened request buses so the mux indexes by sel.
  logic [2:0]        size_a   [NUM_INPUTS];
  logic [ADDR_W-1:0] addr_a   [NUM_INPUTS];
  logic [STRB_W-1:0] strobe_a [NUM_INPUTS];
  logic [DATA_W-1:0] data_a   [NUM_INPUTS];
  logic [3:0]        len_a    [NUM_INPUTS];
  logic [1:0]        burst_a  [NUM_INPUTS];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign size_a[g]   = ireq_size[g*3 +: 3];
    assign addr_a[g]   = ireq_addr[g*ADDR_W +: ADDR_W];
    assign strobe_a[g] = ireq_strobe[g*STRB_W +: STRB_W];
    assign data_a[g]   = ireq_data[g*DATA_W +: DATA_W];
    assign len_a[g]    = ireq_len[g*4 +: 4];
    assign burst_a[g]  = ireq_burst[g*2 +: 2];
  end

  assign win_found = |ireq_valid;

  // Read data is broadcast; only the granted port sees ready/last, which qualifies it.
  assign iresp_data = {NUM_INPUTS{oresp_data}};

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_q;
  logic [SEL_W:0]   cand;

  // Round-robin pick: first valid index scanning rr, rr+1, ... with wrap.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
        cand = cand - (SEL_W+1)'(NUM_INPUTS);
      end
      if (ireq_valid[cand[SEL_W-1:0]]) begin
        win_idx = cand[SEL_W-1:0];
      end
    end
  end

  // Pointer moves to the slot after each winner at grant time.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else if (state_q == IDLE && win_found) begin
      rr_q <= (win_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  // Fixed priority pick: lowest valid index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ireq_valid[i]) begin
        win_idx = SEL_W'(i);
      end
    end
  end
`endif

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, request forwarding and response routing.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    oreq_valid    = 1'b0;
    oreq_is_write = 1'b0;
    oreq_size     = '0;
    oreq_addr     = '0;
    oreq_strobe   = '0;
    oreq_data     = '0;
    oreq_len      = '0;
    oreq_burst    = '0;
    iresp_ready   = '0;
    iresp_last    = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          sel_d   = win_idx;
        end
      end
      BUSY: begin
        // A granted port dropping valid mid-transaction is a protocol error;
        // the grant is held and valid=0 is forwarded as-is.
        oreq_valid         = ireq_valid[sel_q];
        oreq_is_write      = ireq_is_write[sel_q];
        oreq_size          = size_a[sel_q];
        oreq_addr          = addr_a[sel_q];
        oreq_strobe        = strobe_a[sel_q];
        oreq_data          = data_a[sel_q];
        oreq_len           = len_a[sel_q];
        oreq_burst         = burst_a[sel_q];
        iresp_ready[sel_q] = oresp_ready;
        iresp_last[sel_q]  = oresp_last;
        if (oresp_ready && oresp_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: expected grants are queued when requests are driven
// and popped as the arbiter grants; works for both selection builds.
module tb_cbus_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      ireq_valid, ireq_is_write;
  logic [3*N-1:0]    ireq_size;
  logic [AW*N-1:0]   ireq_addr;
  logic [SW*N-1:0]   ireq_strobe;
  logic [DW*N-1:0]   ireq_data;
  logic [4*N-1:0]    ireq_len;
  logic [2*N-1:0]    ireq_burst;
  logic [N-1:0]      iresp_ready, iresp_last;
  logic [DW*N-1:0]   iresp_data;
  logic              oreq_valid, oreq_is_write;
  logic [2:0]        oreq_size;
  logic [AW-1:0]     oreq_addr;
  logic [SW-1:0]     oreq_strobe;
  logic [DW-1:0]     oreq_data;
  logic [3:0]        oreq_len;
  logic [1:0]        oreq_burst;
  logic              oresp_ready, oresp_last;
  logic [DW-1:0]     oresp_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [3:0]    len;
    logic          wr;
  } exp_t;

  exp_t sb[$];
  int   m_rr = 0;

  cbus_arbiter #(.NUM_INPUTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
    .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
    .ireq_len(ireq_len), .ireq_burst(ireq_burst),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
    .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
    .oreq_len(oreq_len), .oreq_burst(oreq_burst),
    .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // Reference selection policy.
  function automatic int model_pick(input logic [N-1:0] v);
    int p = -1;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      int idx = (m_rr + k) % N;
      if (p < 0 && v[idx]) p = idx;
    end
`else
    for (int k = N - 1; k >= 0; k--) if (v[k]) p = k;
`endif
    return p;
  endfunction

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [3:0] l, input logic w);
    ireq_addr[p*AW +: AW] = a;
    ireq_len[p*4 +: 4]    = l;
    ireq_is_write[p]      = w;
  endtask

  task automatic push_exp(input int p);
    exp_t e;
    e.port = p;
    e.addr = ireq_addr[p*AW +: AW];
    e.len  = ireq_len[p*4 +: 4];
    e.wr   = ireq_is_write[p];
    sb.push_back(e);
    m_rr = (p + 1) % N;
  endtask

  // Waits for the next grant, checks it against the queue head, then serves the beats.
  task automatic run_txn(input int beats, input logic [3:0] stall_mask, input bit drop,
                         input logic [N-1:0] raise_mask, input bit pulse, input logic [DW-1:0] dbase);
    exp_t          e;
    int            lat;
    logic [DW-1:0] d;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_last;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL sb_empty: no expected grant queued, want one");
      return;
    end
    e = sb.pop_front();
    lat = 0;
    @(negedge clk);
    while (!oreq_valid && lat < 8) begin
      to_next();
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL grant_latency port %0d: got %0d cycles, want 1", e.port, lat);
    end
    if (!oreq_valid) return;
    vectors++;
    if (oreq_addr !== e.addr) begin
      miscompares++;
      $display("FAIL grant_addr: got %h, want %h (port %0d)", oreq_addr, e.addr, e.port);
    end
    vectors++;
    if (oreq_len !== e.len || oreq_is_write !== e.wr) begin
      miscompares++;
      $display("FAIL grant_fields: got len %0d wr %0b, want len %0d wr %0b", oreq_len, oreq_is_write, e.len, e.wr);
    end
    ireq_valid = ireq_valid | raise_mask;
    exp_rdy = N'(1 << e.port);
    for (int b = 0; b < beats; b++) begin
      if (stall_mask[b]) begin
        oresp_ready = 1'b0; oresp_last = 1'b0;
        #1;
        vectors++;
        if (iresp_ready !== '0 || oreq_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall beat %0d: got ready %b valid %b, want 00 1", b, iresp_ready, oreq_valid);
        end
        to_next();
        @(negedge clk);
      end
      d = dbase + DW'(b);
      oresp_ready = 1'b1;
      oresp_last  = (b == beats - 1);
      oresp_data  = d;
      exp_last    = (b == beats - 1) ? exp_rdy : '0;
      #1;
      vectors++;
      if (iresp_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL resp_ready beat %0d: got %b, want %b", b, iresp_ready, exp_rdy);
      end
      vectors++;
      if (iresp_last !== exp_last) begin
        miscompares++;
        $display("FAIL resp_last beat %0d: got %b, want %b", b, iresp_last, exp_last);
      end
      vectors++;
      if (iresp_data[e.port*DW +: DW] !== d) begin
        miscompares++;
        $display("FAIL resp_data beat %0d: got %h, want %h", b, iresp_data[e.port*DW +: DW], d);
      end
      vectors++;
      if (oreq_addr !== e.addr || oreq_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL grant_held beat %0d: got addr %h valid %b, want %h 1", b, oreq_addr, oreq_valid, e.addr);
      end
      to_next();
      if (pulse && b == 0) ireq_valid = ireq_valid & ~raise_mask;
      if (b != beats - 1) @(negedge clk);
    end
    oresp_ready = 1'b0;
    oresp_last  = 1'b0;
    if (drop) ireq_valid[e.port] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (oreq_valid !== 1'b0 || oreq_addr !== '0 || oreq_len !== '0 || oreq_data !== '0) begin
      miscompares++;
      $display("FAIL reset_oreq: got valid %b addr %h len %0d, want all 0", oreq_valid, oreq_addr, oreq_len);
    end
    vectors++;
    if (iresp_ready !== '0 || iresp_last !== '0) begin
      miscompares++;
      $display("FAIL reset_iresp: got ready %b last %b, want 00 00", iresp_ready, iresp_last);
    end
    vectors++;
    if (int'(dut.state_q) !== 0 || dut.sel_q !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got state %0d sel %0d, want 0 0", int'(dut.state_q), dut.sel_q);
    end
    to_next();
  endtask

  task automatic test_single();
    set_port(1, 64'h0000_0000_8000_0000, 4'd0, 1'b0);
    ireq_valid = 2'b10;
    push_exp(model_pick(ireq_valid));
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    vectors++;
    if (oreq_valid !== 1'b0 || int'(dut.state_q) !== 0) begin
      miscompares++;
      $display("FAIL single_idle_after: got valid %b state %0d, want 0 0", oreq_valid, int'(dut.state_q));
    end
    to_next();
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] v;
    int p;
    set_port(0, 64'h0000_0000_1000_0000, 4'd0, 1'b0);
    set_port(1, 64'h0000_0000_8000_0000, 4'd0, 1'b1);
    v = 2'b11;
    ireq_valid = v;
    for (int k = 0; k < N; k++) begin
      p = model_pick(v);
      push_exp(p);
      v[p] = 1'b0;
    end
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'h1111_0000_0000_0000);
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'h2222_0000_0000_0000);
  endtask

  task automatic test_rr_order();
    ireq_valid = 2'b11;
    for (int k = 0; k < 4; k++) push_exp(model_pick(ireq_valid));
    for (int k = 0; k < 4; k++) run_txn(1, 4'b0000, 1'b0, '0, 1'b0, 64'h3333_0000_0000_0000 + DW'(k * 16));
    ireq_valid = '0;
    to_next();
  endtask

  task automatic test_burst_stall();
    set_port(0, 64'h0000_0000_1000_0040, 4'd3, 1'b1);
    set_port(1, 64'h0000_0000_8000_0040, 4'd0, 1'b0);
    ireq_valid = 2'b01;
    push_exp(model_pick(2'b01));
    push_exp(model_pick(2'b10));
    run_txn(4, 4'b0110, 1'b1, 2'b10, 1'b0, 64'h4444_0000_0000_0000);
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'h5555_0000_0000_0000);
  endtask

  task automatic test_no_preempt();
    set_port(0, 64'h0000_0000_1000_0080, 4'd0, 1'b0);
    set_port(1, 64'h0000_0000_8000_0080, 4'd1, 1'b1);
    ireq_valid = 2'b10;
    push_exp(model_pick(2'b10));
    push_exp(model_pick(2'b01));
    run_txn(2, 4'b0010, 1'b1, 2'b01, 1'b0, 64'h6666_0000_0000_0000);
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'h7777_0000_0000_0000);
  endtask

  task automatic test_drop_ungranted();
    set_port(0, 64'h0000_0000_1000_00C0, 4'd1, 1'b0);
    ireq_valid = 2'b01;
    push_exp(model_pick(2'b01));
    run_txn(2, 4'b0010, 1'b1, 2'b10, 1'b1, 64'h8888_0000_0000_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (oreq_valid !== 1'b0 || iresp_ready !== '0) begin
        miscompares++;
        $display("FAIL drop_stays_idle cycle %0d: got valid %b ready %b, want 0 00", k, oreq_valid, iresp_ready);
      end
      to_next();
    end
  endtask

  task automatic test_reset_mid_burst();
    set_port(1, 64'h0000_0000_8000_0100, 4'd3, 1'b0);
    ireq_valid = 2'b10;
    @(negedge clk);
    to_next();
    @(negedge clk);
    vectors++;
    if (oreq_valid !== 1'b1 || oreq_addr !== 64'h0000_0000_8000_0100) begin
      miscompares++;
      $display("FAIL rst_burst_grant: got valid %b addr %h, want 1 0000000080000100", oreq_valid, oreq_addr);
    end
    oresp_ready = 1'b1; oresp_last = 1'b0; oresp_data = 64'h9999;
    to_next();
    reset = 1'b1;
    oresp_ready = 1'b0;
    to_next();
    reset = 1'b0;
    ireq_valid = '0;
    m_rr = 0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (oreq_valid !== 1'b0 || int'(dut.state_q) !== 0 || dut.sel_q !== '0) begin
      miscompares++;
      $display("FAIL rst_burst_after: got valid %b state %0d sel %0d, want 0 0 0", oreq_valid, int'(dut.state_q), dut.sel_q);
    end
    to_next();
    set_port(0, 64'h0000_0000_1000_0100, 4'd0, 1'b0);
    ireq_valid = 2'b01;
    push_exp(model_pick(2'b01));
    run_txn(1, 4'b0000, 1'b1, '0, 1'b0, 64'hAAAA_0000_0000_0000);
  endtask

  initial begin
    reset         = 1'b1;
    ireq_valid    = '0;
    ireq_is_write = '0;
    ireq_size     = {N{3'd3}};
    ireq_addr     = {64'h0000_0000_8000_0000, 64'h0000_0000_1000_0000};
    ireq_strobe   = '1;
    ireq_data     = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    ireq_len      = '0;
    ireq_burst    = {N{2'b01}};
    oresp_ready   = 1'b0;
    oresp_last    = 1'b0;
    oresp_data    = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_rr_order();
    test_burst_stall();
    test_no_preempt();
    test_drop_ungranted();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- N-way arbiter between the core-side bus adapters (instruction fetch, data access) and the single cbus master port that feeds the memory model.
- Grants one upstream requester at a time and locks the grant for the whole transaction, including bursts.
- While a grant is held, it forwards the granted request downstream and routes the response back to the granted port only.
- Selection policy is fixed priority, or round-robin when the optional feature is enabled.

Parameters:
- NUM_INPUTS, 2, number of upstream requesters (1..8); index 0 = highest fixed priority.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  in  NUM_INPUTS  per-port request valid.
- ireq_is_write  in  NUM_INPUTS  per-port write flag.
- ireq_size  in  3*NUM_INPUTS  per-port beat size code.
- ireq_addr  in  ADDR_W*NUM_INPUTS  per-port address.
- ireq_strobe  in  (DATA_W/8)*NUM_INPUTS  per-port byte strobes.
- ireq_data  in  DATA_W*NUM_INPUTS  per-port write data.
- ireq_len  in  4*NUM_INPUTS  per-port burst length code (beats-1).
- ireq_burst  in  2*NUM_INPUTS  per-port burst type.
- iresp_ready  out  NUM_INPUTS  per-port beat accepted/valid.
- iresp_last  out  NUM_INPUTS  per-port final beat.
- iresp_data  out  DATA_W*NUM_INPUTS  per-port read data (same downstream data broadcast to every slice).
- oreq_valid  out  1  downstream request valid.
- oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len, oreq_burst  out  1/3/ADDR_W/DATA_W/8/DATA_W/4/2  downstream request fields.
- oresp_ready  in  1  downstream beat handshake.
- oresp_last  in  1  downstream final beat.
- oresp_data  in  DATA_W  downstream read data.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- State: IDLE, BUSY; registered grant index `sel` (clog2(NUM_INPUTS) bits, min 1).
- Reset: state=IDLE, sel=0, round-robin pointer=0.
- Outputs in IDLE: oreq_valid=0; all other oreq_* fields=0; iresp_ready=0; iresp_last=0.
- IDLE, any ireq_valid=1: pick winner per policy, latch sel, go to BUSY next cycle.
- Grant latency: exactly 1 cycle from first sampled valid to oreq_valid=1.
- IDLE, no valid: stay IDLE.
- BUSY forwarding: oreq_* = ireq_*[sel] combinationally, including oreq_valid = ireq_valid[sel].
- BUSY response routing: iresp_ready[sel] = oresp_ready and iresp_last[sel] = oresp_last; all other ports read 0.
- BUSY exit: on oresp_ready && oresp_last, return to IDLE next cycle. There is no back-to-back grant; at least one IDLE cycle separates transactions.
- Grant is non-preemptive: a higher-priority valid arriving during BUSY waits.
- Upstream must hold valid and fields stable until its last beat. If ireq_valid[sel] drops mid-transaction, the arbiter stays BUSY and forwards valid=0 (protocol violation; not recovered).
- Simultaneous requests in IDLE are resolved by the policy.
- A port whose valid drops while it is not granted simply loses its turn.
- Reset asserted mid-burst: next cycle IDLE, oreq_valid=0. The downstream must also be reset.
- Single-beat transaction (len=0): oresp_last coincides with the first oresp_ready.

Optional Feature:
- Macro: CBUS_ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin. Pointer `rr` holds the index after the last winner. The winner is the first valid index scanning rr, rr+1, ... with wrap modulo NUM_INPUTS. On grant, rr = winner+1 (wraps to 0 after NUM_INPUTS-1).
- Undefined: fixed priority, lowest valid index wins; no rr register is synthesised.

Test Plan:
- Single port 1 read, len=0, addr 0x8000_0000: oreq_valid rises 1 cycle after ireq_valid[1]. Response data 0xDEAD_BEEF with last appears only on iresp_*[1]. The arbiter is IDLE the cycle after last.
- Both ports valid simultaneously in IDLE (fixed priority): port 0 is granted first; port 1 is granted one cycle after port 0's last beat.
- Round-robin build, both ports continuously valid, four single-beat transactions: grant order 0,1,0,1.
- Port 0 4-beat burst (len=3) write with ready stalls on beats 2–3: grant is held until the 4th beat with last. Port 1, valid from beat 1, sees iresp_ready=0 throughout, then is granted.
- Reset asserted during beat 2 of a 4-beat burst: the following cycle oreq_valid=0, state IDLE, sel=0. A new request afterwards is granted normally with 1-cycle latency.
- Port 1 only valid for one cycle while port 0 is BUSY and then drops: port 1 is never granted. After port 0 completes, the arbiter stays IDLE.
